switch_key_driver: RTL and testbench

- Input-side counterpart to the LED tube display peripheral: the CPU reads board input through it instead of writing display data.
- Samples 64 DIP switches (8 banks × 8) and 8 push keys, all active-low on the board. Synchronises and debounces every input, then presents clean active-high levels to the CPU bus.
- Latches key presses for software polling and raises an optional interrupt.
- Sits beside the display driver on the bridge; uses the same WE/Addr/WD/RD slave port, decoded by the bridge.

---
 rtl/switch_key_driver_pkg.sv | 21 ++
 rtl/switch_key_driver_debounce_channel.sv | 55 +++++
 rtl/switch_key_driver.sv | 122 ++++++++++++
 tb/tb_switch_key_driver.sv | 358 +++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/switch_key_driver_pkg.sv
// Shared constants for the board-input peripheral that sits beside the LED tube display driver.
// Register offsets are word indices, i.e. Address[3:2] as decoded by the bridge.
package switch_key_driver_pkg;

    localparam int DISPLAY_SCALE = 25000;

    localparam int SWK_TICK_CYCLES  = 25000;
    localparam int SWK_STABLE_TICKS = 4;
    localparam int SWK_STB_W        = 3;

    localparam logic [1:0] SWK_ADDR_SW_LO = 2'd0;
    localparam logic [1:0] SWK_ADDR_SW_HI = 2'd1;
    localparam logic [1:0] SWK_ADDR_KEY   = 2'd2;
    localparam logic [1:0] SWK_ADDR_MASK  = 2'd3;

    function automatic logic [31:0] swk_key_word(input logic [7:0] press,
                                                 input logic [7:0] level);
        return {16'b0, press, level};
    endfunction

endpackage

// File: rtl/switch_key_driver_debounce_channel.sv
// One debounced input: 2-flop synchroniser on the active-low raw pin, then a tick-driven
// stability counter that accepts a new level only after STABLE_TICKS consecutive disagreeing samples.
module switch_key_driver_debounce_channel
    import switch_key_driver_pkg::*;
#(
    parameter int STABLE_TICKS = SWK_STABLE_TICKS,
    parameter int STB_W        = SWK_STB_W
) (
    input  logic Clock,
    input  logic Reset,
    input  logic tick,
    input  logic raw_n,
    output logic level
);

    localparam logic [STB_W-1:0] STB_LAST = STB_W'(STABLE_TICKS - 1);

    logic             sync_1;
    logic             sync_2;
    logic             sample;
    logic             deb;
    logic [STB_W-1:0] stb;

    // Synchroniser resets to the released level so nothing looks pressed out of reset.
    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            sync_1 <= 1'b1;
            sync_2 <= 1'b1;
        end else begin
            sync_1 <= raw_n;
            sync_2 <= sync_1;
        end
    end

    assign sample = ~sync_2;

    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            deb <= 1'b0;
            stb <= '0;
        end else if (tick) begin
            if (sample == deb) begin
                stb <= '0;
            end else if (stb == STB_LAST) begin
                deb <= sample;
                stb <= '0;
            end else begin
                stb <= stb + STB_W'(1);
            end
        end
    end

    assign level = deb;

endmodule

// File: rtl/switch_key_driver.sv
// CPU-readable DIP switch / push key peripheral with debounce, press latch and W1C.
// Define SWITCH_KEY_IRQ_EN to build the mask register and key interrupt; otherwise IRQ is tied 0.
module switch_key_driver
    import switch_key_driver_pkg::*;
#(
    parameter int TICK_CYCLES  = SWK_TICK_CYCLES,
    parameter int STABLE_TICKS = SWK_STABLE_TICKS,
    parameter int STB_W        = SWK_STB_W
) (
    input  logic        Clock,
    input  logic        Reset,
    input  logic        WE,
    input  logic [1:0]  Addr,
    input  logic [31:0] WD,
    output logic [31:0] RD,
    input  logic [63:0] Switch,
    input  logic [7:0]  Key,
    output logic        IRQ
);

    localparam int TICK_W = (TICK_CYCLES > 1) ? $clog2(TICK_CYCLES) : 1;
    localparam logic [TICK_W-1:0] TICK_LAST = TICK_W'(TICK_CYCLES - 1);
    localparam int NCH = 72;

    logic [TICK_W-1:0] tick_cnt;
    logic              tick;
    logic [NCH-1:0]    raw_all;
    logic [NCH-1:0]    deb_all;
    logic [63:0]       deb_switch;
    logic [7:0]        deb_key;
    logic [7:0]        key_prev;
    logic [7:0]        key_rise;
    logic [7:0]        key_clr;
    logic [7:0]        press;

    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            tick_cnt <= '0;
        end else if (tick) begin
            tick_cnt <= '0;
        end else begin
            tick_cnt <= tick_cnt + TICK_W'(1);
        end
    end

    assign tick = (tick_cnt == TICK_LAST);

    // Channels 0..63 are the switch banks, 64..71 the keys.
    assign raw_all = {Key, Switch};

    for (genvar c = 0; c < NCH; c++) begin : g_chan
        switch_key_driver_debounce_channel #(
            .STABLE_TICKS (STABLE_TICKS),
            .STB_W        (STB_W)
        ) u_chan (
            .Clock (Clock),
            .Reset (Reset),
            .tick  (tick),
            .raw_n (raw_all[c]),
            .level (deb_all[c])
        );
    end

    assign deb_switch = deb_all[63:0];
    assign deb_key    = deb_all[71:64];

    assign key_rise = deb_key & ~key_prev;
    assign key_clr  = (WE && (Addr == SWK_ADDR_KEY)) ? WD[15:8] : 8'h00;

    // A press edge landing in the same cycle as its W1C survives: set is ORed in after the clear.
    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            key_prev <= '0;
            press    <= '0;
        end else begin
            key_prev <= deb_key;
            press    <= (press & ~key_clr) | key_rise;
        end
    end

`ifdef SWITCH_KEY_IRQ_EN
    logic [7:0] mask;
    logic       irq_q;
    logic       unused_wd;

    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            mask  <= '0;
            irq_q <= 1'b0;
        end else begin
            if (WE && (Addr == SWK_ADDR_MASK)) begin
                mask <= WD[7:0];
            end
            irq_q <= |(press & mask);
        end
    end

    assign IRQ       = irq_q;
    assign unused_wd = ^WD[31:16];
`else
    logic unused_wd;

    assign IRQ       = 1'b0;
    assign unused_wd = ^{WD[31:16], WD[7:0]};
`endif

    always_comb begin
        RD = 32'h0;
        case (Addr)
            SWK_ADDR_SW_LO: RD = deb_switch[31:0];
            SWK_ADDR_SW_HI: RD = deb_switch[63:32];
            SWK_ADDR_KEY:   RD = swk_key_word(press, deb_key);
`ifdef SWITCH_KEY_IRQ_EN
            SWK_ADDR_MASK:  RD = {24'b0, mask};
`else
            SWK_ADDR_MASK:  RD = 32'h0;
`endif
            default:        RD = 32'h0;
        endcase
    end

endmodule

// File: tb/tb_switch_key_driver.sv
// Self-checking bench for switch_key_driver with a history-based debounce reference model.
// Honours SWITCH_KEY_IRQ_EN the same way as the design.
module tb_switch_key_driver;

    localparam int TICK_CYCLES  = 4;
    localparam int STABLE_TICKS = 3;
    localparam int STB_W        = 2;
    localparam int NCH          = 72;
`ifdef SWITCH_KEY_IRQ_EN
    localparam logic IRQ_ON = 1'b1;
`else
    localparam logic IRQ_ON = 1'b0;
`endif

    logic        Clock;
    logic        Reset;
    logic        WE;
    logic [1:0]  Addr;
    logic [31:0] WD;
    logic [31:0] RD;
    logic [63:0] Switch;
    logic [7:0]  Key;
    logic        IRQ;

    int n_cmp = 0;
    int n_bad = 0;

    switch_key_driver #(
        .TICK_CYCLES  (TICK_CYCLES),
        .STABLE_TICKS (STABLE_TICKS),
        .STB_W        (STB_W)
    ) dut (
        .Clock  (Clock),
        .Reset  (Reset),
        .WE     (WE),
        .Addr   (Addr),
        .WD     (WD),
        .RD     (RD),
        .Switch (Switch),
        .Key    (Key),
        .IRQ    (IRQ)
    );

    initial begin
        Clock = 1'b0;
        forever #5 Clock = ~Clock;
    end

    // Reference model: a level flips once the last STABLE_TICKS tick samples all disagree with it.
    logic [NCH-1:0]          m_s1, m_s2, m_deb, m_nd;
    logic [STABLE_TICKS-1:0] m_hist [NCH];
    logic [STABLE_TICKS-1:0] m_hn   [NCH];
    logic [7:0]              m_pend, m_press, m_mask, m_clr;
    logic                    m_irq, m_tick;
    int                      m_cnt;

    always_comb begin
        m_tick = (m_cnt == TICK_CYCLES - 1);
        m_nd   = m_deb;
        for (int c = 0; c < NCH; c++) begin
            m_hn[c] = {m_hist[c][STABLE_TICKS-2:0], ~m_s2[c]};
            if (m_tick && (m_hn[c] == {STABLE_TICKS{~m_deb[c]}}))
                m_nd[c] = ~m_deb[c];
        end
        m_clr = (WE && Addr == 2'd2) ? WD[15:8] : 8'h00;
    end

    always @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            m_s1    <= '1;
            m_s2    <= '1;
            m_deb   <= '0;
            m_cnt   <= 0;
            m_pend  <= '0;
            m_press <= '0;
            m_mask  <= '0;
            m_irq   <= 1'b0;
            for (int c = 0; c < NCH; c++) m_hist[c] <= '0;
        end else begin
            m_s1    <= {Key, Switch};
            m_s2    <= m_s1;
            m_cnt   <= m_tick ? 0 : m_cnt + 1;
            m_deb   <= m_nd;
            if (m_tick)
                for (int c = 0; c < NCH; c++) m_hist[c] <= m_hn[c];
            m_pend  <= m_nd[71:64] & ~m_deb[71:64];
            m_press <= (m_press & ~m_clr) | m_pend;
            m_irq   <= |(m_press & m_mask);
`ifdef SWITCH_KEY_IRQ_EN
            if (WE && Addr == 2'd3) m_mask <= WD[7:0];
`endif
        end
    end

    function automatic logic [31:0] exp_rd(input logic [1:0] a);
        case (a)
            2'd0:    return m_deb[31:0];
            2'd1:    return m_deb[63:32];
            2'd2:    return {16'b0, m_press, m_deb[71:64]};
            default: return IRQ_ON ? {24'b0, m_mask} : 32'h0;
        endcase
    endfunction

    task automatic idle(input int n);
        repeat (n) @(negedge Clock);
    endtask

    task automatic test_reset();
        Reset = 1'b1; WE = 1'b0; Addr = 2'd0; WD = '0;
        Switch = '1; Key = '1;
        idle(3);
        Reset = 1'b0;
        Switch[5] = 1'b0;
        Key[1]    = 1'b0;
        idle(25);
        Addr = 2'd2; #1;
        n_cmp++;
        if (RD !== exp_rd(2'd2))
            $display("FAIL pre_reset_key: got %h expected %h", RD, exp_rd(2'd2));
        @(posedge Clock); #2;
        Reset = 1'b1; #1;
        for (int a = 0; a < 4; a++) begin
            Addr = a[1:0]; #1;
            n_cmp++;
            if (RD !== 32'h0) begin
                n_bad++;
                $display("FAIL reset_rd addr %0d: got %h expected %h", a, RD, 32'h0);
            end
        end
        n_cmp++;
        if (IRQ !== 1'b0) begin
            n_bad++;
            $display("FAIL reset_irq: got %b expected 0", IRQ);
        end
        Switch = '1; Key = '1;
        @(negedge Clock);
        Reset = 1'b0;
        for (int i = 0; i < 30; i++) begin
            @(negedge Clock);
            Addr = i[1:0]; #1;
            n_cmp++;
            if (RD !== 32'h0) begin
                n_bad++;
                $display("FAIL reset_hold addr %0d: got %h expected %h", i % 4, RD, 32'h0);
            end
        end
    endtask

    task automatic test_clean_switch();
        int lat;
        lat = -1;
        @(negedge Clock);
        Switch[0] = 1'b0;
        Addr = 2'd0;
        for (int i = 1; i <= 30 && lat < 0; i++) begin
            @(negedge Clock); #1;
            n_cmp++;
            if (RD !== exp_rd(2'd0)) begin
                n_bad++;
                $display("FAIL sw0_model: got %h expected %h", RD, exp_rd(2'd0));
            end
            if (RD === 32'h1) lat = i;
        end
        n_cmp++;
        if (lat < 11 || lat > 18) begin
            n_bad++;
            $display("FAIL sw0_latency: got %0d cycles expected 11..18", lat);
        end
        Switch[63] = 1'b0;
        Addr = 2'd1;
        idle(20); #1;
        n_cmp++;
        if (RD !== 32'h8000_0000) begin
            n_bad++;
            $display("FAIL sw63_hi: got %h expected %h", RD, 32'h8000_0000);
        end
        Switch = '1;
        idle(20);
        Addr = 2'd0; #1;
        n_cmp++;
        if (RD !== 32'h0) begin
            n_bad++;
            $display("FAIL sw_release: got %h expected %h", RD, 32'h0);
        end
    endtask

    task automatic test_glitch();
        Addr = 2'd2;
        for (int i = 0; i < 38; i++) begin
            Key[2] = (i >= 8 && i < 12);
            @(negedge Clock); #1;
            n_cmp++;
            if (RD !== exp_rd(2'd2)) begin
                n_bad++;
                $display("FAIL glitch_model step %0d: got %h expected %h", i, RD, exp_rd(2'd2));
            end
            if (i == 19) begin
                n_cmp++;
                if (RD !== 32'h0) begin
                    n_bad++;
                    $display("FAIL glitch_reject: got %h expected %h", RD, 32'h0);
                end
            end
        end
        n_cmp++;
        if (RD !== 32'h0000_0404) begin
            n_bad++;
            $display("FAIL glitch_accept: got %h expected %h", RD, 32'h0000_0404);
        end
    endtask

    task automatic test_latch_w1c();
        Key[2] = 1'b1;
        idle(20); #1;
        n_cmp++;
        if (RD !== 32'h0000_0400) begin
            n_bad++;
            $display("FAIL latch_hold: got %h expected %h", RD, 32'h0000_0400);
        end
        WE = 1'b1; WD = 32'h0000_0400;
        @(negedge Clock);
        WE = 1'b0; #1;
        n_cmp++;
        if (RD !== 32'h0) begin
            n_bad++;
            $display("FAIL w1c_clear: got %h expected %h", RD, 32'h0);
        end
    endtask

    task automatic test_collision();
        logic done;
        done = 1'b0;
        Addr = 2'd2;
        Key[5] = 1'b0;
        for (int i = 0; i < 40 && !done; i++) begin
            @(negedge Clock); #1;
            if (m_pend[5]) begin
                WE = 1'b1; WD = 32'h0000_2000;
                @(negedge Clock);
                WE = 1'b0; #1;
                n_cmp++;
                if (RD[13] !== 1'b1) begin
                    n_bad++;
                    $display("FAIL collision_set_wins: got %b expected 1", RD[13]);
                end
                done = 1'b1;
            end
        end
        n_cmp++;
        if (done !== 1'b1) begin
            n_bad++;
            $display("FAIL collision_timeout: got %b expected 1", done);
        end
        Key[5] = 1'b1;
        idle(20);
        WE = 1'b1; WD = 32'h0000_2000;
        @(negedge Clock);
        WE = 1'b0; #1;
        n_cmp++;
        if (RD !== 32'h0) begin
            n_bad++;
            $display("FAIL collision_clear: got %h expected %h", RD, 32'h0);
        end
    endtask

    task automatic test_irq();
        logic seen;
        seen = 1'b0;
        WE = 1'b1; Addr = 2'd3; WD = 32'h0000_0004;
        @(negedge Clock);
        WE = 1'b0; #1;
        n_cmp++;
        if (RD !== (IRQ_ON ? 32'h4 : 32'h0)) begin
            n_bad++;
            $display("FAIL mask_read: got %h expected %h", RD, IRQ_ON ? 32'h4 : 32'h0);
        end
        Addr = 2'd2;
        Key[2] = 1'b0;
        for (int i = 0; i < 40 && !seen; i++) begin
            @(negedge Clock); #1;
            if (RD[10] === 1'b1) begin
                seen = 1'b1;
                n_cmp++;
                if (IRQ !== 1'b0) begin
                    n_bad++;
                    $display("FAIL irq_early: got %b expected 0", IRQ);
                end
                @(negedge Clock); #1;
                n_cmp++;
                if (IRQ !== IRQ_ON) begin
                    n_bad++;
                    $display("FAIL irq_set: got %b expected %b", IRQ, IRQ_ON);
                end
                WE = 1'b1; WD = 32'h0000_0400;
                @(negedge Clock);
                WE = 1'b0; #1;
                n_cmp++;
                if (IRQ !== IRQ_ON) begin
                    n_bad++;
                    $display("FAIL irq_write_cycle: got %b expected %b", IRQ, IRQ_ON);
                end
                @(negedge Clock); #1;
                n_cmp++;
                if (IRQ !== 1'b0) begin
                    n_bad++;
                    $display("FAIL irq_clear: got %b expected 0", IRQ);
                end
            end
        end
        n_cmp++;
        if (seen !== 1'b1) begin
            n_bad++;
            $display("FAIL irq_press_timeout: got %b expected 1", seen);
        end
        Key[2] = 1'b1;
        idle(20);
    endtask

    task automatic test_random();
        int hold;
        for (int it = 0; it < 150; it++) begin
            Switch = Switch ^ ({$urandom, $urandom} & {$urandom, $urandom} & {$urandom, $urandom});
            Key    = Key ^ (8'($urandom) & 8'($urandom));
            hold   = $urandom_range(1, 24);
            for (int c = 0; c < hold; c++) begin
                WE   = ($urandom_range(0, 7) == 0);
                Addr = 2'($urandom);
                WD   = $urandom;
                @(negedge Clock);
                WE   = 1'b0;
                Addr = 2'($urandom); #1;
                n_cmp++;
                if (RD !== exp_rd(Addr)) begin
                    n_bad++;
                    $display("FAIL rand_rd addr %0d: got %h expected %h", Addr, RD, exp_rd(Addr));
                end
                n_cmp++;
                if (IRQ !== m_irq) begin
                    n_bad++;
                    $display("FAIL rand_irq: got %b expected %b", IRQ, m_irq);
                end
            end
        end
    endtask

    initial begin
        test_reset();
        test_clean_switch();
        test_glitch();
        test_latch_w1c();
        test_collision();
        test_irq();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
